// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Schedules one frame through the capture -> grayscale -> filter pipeline and
// drives the enable / direction strobes of the two frame memories and the
// processing engines. Supports single-shot and continuous operation, a sticky
// "stop after this frame" request, a per-phase watchdog and a wrapping
// completed-frame counter.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        begin sequencing (only looked at in IDLE or ERROR)
//   stop         halt after the current frame completes
//   continuous   1 = run frames back-to-back, 0 = one frame per start
//   cam_done     capture into RWM_1 finished
//   gs_done      grayscale pass (RWM_1 -> RWM_2) finished
//   rd_done      readout of RWM_2 into the filter/display finished
//   cam_en       camera/image source enable
//   rwm1_en      RWM_1 enable
//   rwm1_rw      RWM_1 direction, 1 = write, 0 = read
//   rwm2_en      RWM_2 enable
//   rwm2_rw      RWM_2 direction, 1 = write, 0 = read
//   gs_en        grayscaler enable
//   flt_en       filter/display path enable
//   busy         high in CAPTURE, GRAY, FILTER and DONE
//   frame_done   one-cycle pulse per completed frame
//   timeout_err  high while parked in ERROR
//   frame_count  completed frames, wraps at 2^CNT_W
//   state        current state code (debug)
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int                   TIMEOUT_W = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'd1000000,
    parameter int                   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    input  logic             cam_done,
    input  logic             gs_done,
    input  logic             rd_done,
    output logic             cam_en,
    output logic             rwm1_en,
    output logic             rwm1_rw,
    output logic             rwm2_en,
    output logic             rwm2_rw,
    output logic             gs_en,
    output logic             flt_en,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] frame_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_GRAY    = 3'd2,
        S_FILTER  = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    // Last watchdog value a phase may reach before it is declared hung.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT - 1'b1;

    state_t               state_q,       state_d;
    logic                 stop_pend_q,   stop_pend_d;
    logic [TIMEOUT_W-1:0] wd_q,          wd_d;
    logic [CNT_W-1:0]     cnt_q,         cnt_d;

    logic cam_en_q,      cam_en_d;
    logic rwm1_en_q,     rwm1_en_d;
    logic rwm1_rw_q,     rwm1_rw_d;
    logic rwm2_en_q,     rwm2_en_d;
    logic rwm2_rw_q,     rwm2_rw_d;
    logic gs_en_q,       gs_en_d;
    logic flt_en_q,      flt_en_d;
    logic busy_q,        busy_d;
    logic frame_done_q,  frame_done_d;
    logic timeout_err_q, timeout_err_d;

    logic in_phase;
    logic in_busy;

    // -------------------------------------------------------------------------
    // Next-state, watchdog, stop request and frame counter
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        wd_d        = wd_q;
        cnt_d       = cnt_q;
        in_phase    = 1'b0;
        in_busy     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                in_phase = 1'b1;
                in_busy  = 1'b1;
                // done takes priority over a coincident watchdog expiry
                if (cam_done)            state_d = S_GRAY;
                else if (wd_q == WD_LAST) state_d = S_ERROR;
            end
            S_GRAY: begin
                in_phase = 1'b1;
                in_busy  = 1'b1;
                if (gs_done)             state_d = S_FILTER;
                else if (wd_q == WD_LAST) state_d = S_ERROR;
            end
            S_FILTER: begin
                in_phase = 1'b1;
                in_busy  = 1'b1;
                if (rd_done)             state_d = S_DONE;
                else if (wd_q == WD_LAST) state_d = S_ERROR;
            end
            S_DONE: begin
                in_busy = 1'b1;
                // stop_pend is the registered copy, so a stop arriving in
                // DONE itself only takes effect at the end of the next frame
                if (continuous && !stop_pend_q) state_d = S_CAPTURE;
                else                            state_d = S_IDLE;
            end
            S_ERROR: begin
                if (start) state_d = S_CAPTURE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop && in_busy) stop_pend_d = 1'b1;
        // Entering IDLE consumes any pending stop (wins over a new one)
        if (state_d == S_IDLE && state_q != S_IDLE) stop_pend_d = 1'b0;

        if (state_d != state_q) wd_d = '0;
        else if (in_phase)      wd_d = wd_q + 1'b1;
        else                    wd_d = '0;

        if (state_d == S_DONE && state_q != S_DONE) cnt_d = cnt_q + 1'b1;
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, registered alongside it so that the
    // strobes always match the registered state code
    // -------------------------------------------------------------------------
    always_comb begin
        cam_en_d      = 1'b0;
        rwm1_en_d     = 1'b0;
        rwm1_rw_d     = 1'b0;
        rwm2_en_d     = 1'b0;
        rwm2_rw_d     = 1'b0;
        gs_en_d       = 1'b0;
        flt_en_d      = 1'b0;
        busy_d        = 1'b0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;

        case (state_d)
            S_CAPTURE: begin
                cam_en_d  = 1'b1;
                rwm1_en_d = 1'b1;
                rwm1_rw_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_GRAY: begin
                gs_en_d   = 1'b1;
                rwm1_en_d = 1'b1;
                rwm2_en_d = 1'b1;
                rwm2_rw_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_FILTER: begin
                rwm2_en_d = 1'b1;
                flt_en_d  = 1'b1;
                busy_d    = 1'b1;
            end
            S_DONE: begin
                busy_d       = 1'b1;
                frame_done_d = 1'b1;
            end
            S_ERROR: begin
                timeout_err_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            stop_pend_q   <= 1'b0;
            wd_q          <= '0;
            cnt_q         <= '0;
            cam_en_q      <= 1'b0;
            rwm1_en_q     <= 1'b0;
            rwm1_rw_q     <= 1'b0;
            rwm2_en_q     <= 1'b0;
            rwm2_rw_q     <= 1'b0;
            gs_en_q       <= 1'b0;
            flt_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stop_pend_q   <= stop_pend_d;
            wd_q          <= wd_d;
            cnt_q         <= cnt_d;
            cam_en_q      <= cam_en_d;
            rwm1_en_q     <= rwm1_en_d;
            rwm1_rw_q     <= rwm1_rw_d;
            rwm2_en_q     <= rwm2_en_d;
            rwm2_rw_q     <= rwm2_rw_d;
            gs_en_q       <= gs_en_d;
            flt_en_q      <= flt_en_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cam_en      = cam_en_q;
    assign rwm1_en     = rwm1_en_q;
    assign rwm1_rw     = rwm1_rw_q;
    assign rwm2_en     = rwm2_en_q;
    assign rwm2_rw     = rwm2_rw_q;
    assign gs_en       = gs_en_q;
    assign flt_en      = flt_en_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;
    assign frame_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
//
// Drives frames with randomized phase lengths and compares the observed state
// and strobe trace against a reference built from the phase rules: a frame is
// CAPTURE for d1 cycles, GRAY for d2, FILTER for d3, then one DONE cycle, and
// the completed-frame count advances modulo 2^CNT_W.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

    localparam int CNT_W = 2;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop, continuous;
    logic             cam_done, gs_done, rd_done;
    logic             cam_en, rwm1_en, rwm1_rw, rwm2_en, rwm2_rw;
    logic             gs_en, flt_en, busy, frame_done, timeout_err;
    logic [CNT_W-1:0] frame_count;
    logic [2:0]       state;
    logic [9:0]       outs;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    int         tr_state[$];
    logic [9:0] tr_outs[$];
    int         exp_state[$];
    int         cnt_seen[$];
    int         exp_cnt_seq[$];

    frame_sequencer #(
        .TIMEOUT_W (24),
        .TIMEOUT   (24'd16),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .cam_done    (cam_done),
        .gs_done     (gs_done),
        .rd_done     (rd_done),
        .cam_en      (cam_en),
        .rwm1_en     (rwm1_en),
        .rwm1_rw     (rwm1_rw),
        .rwm2_en     (rwm2_en),
        .rwm2_rw     (rwm2_rw),
        .gs_en       (gs_en),
        .flt_en      (flt_en),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .frame_count (frame_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    assign outs = {cam_en, rwm1_en, rwm1_rw, rwm2_en, rwm2_rw,
                   gs_en, flt_en, busy, frame_done, timeout_err};

    // Reference strobe pattern per state, in the order of 'outs'
    function automatic logic [9:0] exp_outs(input int s);
        case (s)
            1:       return 10'b1110000100;
            2:       return 10'b0101110100;
            3:       return 10'b0001001100;
            4:       return 10'b0000000110;
            5:       return 10'b0000000001;
            default: return 10'b0000000000;
        endcase
    endfunction

    // Reference: one completed frame with the given phase lengths
    task automatic model_frame(input int d1, input int d2, input int d3);
        repeat (d1) exp_state.push_back(1);
        repeat (d2) exp_state.push_back(2);
        repeat (d3) exp_state.push_back(3);
        exp_state.push_back(4);
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        exp_cnt_seq.push_back(exp_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic record();
        tr_state.push_back(int'(state));
        tr_outs.push_back(outs);
    endtask

    task automatic clear_traces();
        tr_state.delete();
        tr_outs.delete();
        exp_state.delete();
        cnt_seen.delete();
        exp_cnt_seq.delete();
    endtask

    // Drives one frame: each phase lasts d[p] cycles, its done asserted on the
    // last of them. Optionally pulses stop in GRAY and stray inputs at the
    // start of CAPTURE and FILTER. Ends one cycle after DONE.
    task automatic run_frame(input int d1, input int d2, input int d3,
                             input bit do_start, input bit do_stop,
                             input bit do_stray);
        int d[3];
        d[0] = d1; d[1] = d2; d[2] = d3;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        record();
        for (int p = 0; p < 3; p++) begin
            for (int k = 1; k <= d[p]; k++) begin
                if (do_stray && k == 1 && p == 0) begin
                    gs_done = 1'b1; rd_done = 1'b1; start = 1'b1;
                end
                if (do_stray && k == 1 && p == 2) begin
                    cam_done = 1'b1; gs_done = 1'b1; start = 1'b1;
                end
                if (do_stop && p == 1 && k == 1) stop = 1'b1;
                if (k == d[p]) begin
                    case (p)
                        0:       cam_done = 1'b1;
                        1:       gs_done  = 1'b1;
                        default: rd_done  = 1'b1;
                    endcase
                end
                tick();
                cam_done = 1'b0; gs_done = 1'b0; rd_done = 1'b0;
                stop = 1'b0; start = 1'b0;
                record();
            end
        end
        cnt_seen.push_back(int'(frame_count));
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; stop = 0; continuous = 0;
        cam_done = 0; gs_done = 0; rd_done = 0;
        #12;
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        checks++;
        if (outs !== 10'd0) begin
            errors++;
            $display("FAIL reset_outs: got %b expected 0", outs);
        end
        checks++;
        if (frame_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", frame_count);
        end
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        tick();
    endtask

    task automatic test_single_frame();
        continuous = 1'b0;
        for (int f = 0; f < 3; f++) begin
            int d1, d2, d3;
            clear_traces();
            d1 = $urandom_range(1, 14);
            d2 = $urandom_range(1, 14);
            d3 = $urandom_range(1, 14);
            run_frame(d1, d2, d3, 1'b1, 1'b0, 1'b0);
            model_frame(d1, d2, d3);
            checks++;
            if (tr_state.size() != exp_state.size()) begin
                errors++;
                $display("FAIL single_len: got %0d expected %0d", tr_state.size(), exp_state.size());
            end else begin
                for (int i = 0; i < exp_state.size(); i++) begin
                    checks++;
                    if (tr_state[i] !== exp_state[i] || tr_outs[i] !== exp_outs(exp_state[i])) begin
                        errors++;
                        $display("FAIL single_trace[%0d]: state=%0d outs=%b expected state=%0d outs=%b",
                                 i, tr_state[i], tr_outs[i], exp_state[i], exp_outs(exp_state[i]));
                    end
                end
            end
            checks++;
            if (cnt_seen[0] !== exp_cnt_seq[0]) begin
                errors++;
                $display("FAIL single_count: got %0d expected %0d", cnt_seen[0], exp_cnt_seq[0]);
            end
            checks++;
            if (state !== 3'd0 || outs !== 10'd0) begin
                errors++;
                $display("FAIL single_after: state=%0d outs=%b expected state=0 outs=0", state, outs);
            end
        end
    endtask

    task automatic test_continuous_stop();
        int d[9];
        clear_traces();
        continuous = 1'b1;
        for (int i = 0; i < 9; i++) d[i] = $urandom_range(1, 14);
        run_frame(d[0], d[1], d[2], 1'b1, 1'b0, 1'b0);
        run_frame(d[3], d[4], d[5], 1'b0, 1'b0, 1'b0);
        run_frame(d[6], d[7], d[8], 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) model_frame(d[3*f], d[3*f+1], d[3*f+2]);
        checks++;
        if (tr_state.size() != exp_state.size()) begin
            errors++;
            $display("FAIL cont_len: got %0d expected %0d", tr_state.size(), exp_state.size());
        end else begin
            for (int i = 0; i < exp_state.size(); i++) begin
                checks++;
                if (tr_state[i] !== exp_state[i] || tr_outs[i] !== exp_outs(exp_state[i])) begin
                    errors++;
                    $display("FAIL cont_trace[%0d]: state=%0d outs=%b expected state=%0d outs=%b",
                             i, tr_state[i], tr_outs[i], exp_state[i], exp_outs(exp_state[i]));
                end
            end
        end
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (cnt_seen[f] !== exp_cnt_seq[f]) begin
                errors++;
                $display("FAIL cont_count[%0d]: got %0d expected %0d", f, cnt_seen[f], exp_cnt_seq[f]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== 3'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL cont_halt[%0d]: state=%0d busy=%0d expected state=0 busy=0", i, state, busy);
            end
            tick();
        end
        continuous = 1'b0;
    endtask

    task automatic test_watchdog();
        int n;
        clear_traces();
        continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL wd_enter: got state %0d expected 1", state);
        end
        n = 0;
        while (state == 3'd1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("FAIL wd_cycles: got %0d expected %0d", n, TMO);
        end
        checks++;
        if (state !== 3'd5 || outs !== exp_outs(5)) begin
            errors++;
            $display("FAIL wd_error: state=%0d outs=%b expected state=5 outs=%b", state, outs, exp_outs(5));
        end
        checks++;
        if (int'(frame_count) !== exp_cnt) begin
            errors++;
            $display("FAIL wd_count: got %0d expected %0d", frame_count, exp_cnt);
        end
        // stop and stray dones in ERROR change nothing
        stop = 1'b1; cam_done = 1'b1;
        tick();
        stop = 1'b0; cam_done = 1'b0;
        checks++;
        if (state !== 3'd5 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_hold: state=%0d timeout_err=%0d expected state=5 timeout_err=1", state, timeout_err);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (state !== 3'd1 || outs !== exp_outs(1)) begin
            errors++;
            $display("FAIL wd_restart: state=%0d outs=%b expected state=1 outs=%b", state, outs, exp_outs(1));
        end
        run_frame(3, 4, 5, 1'b0, 1'b0, 1'b0);
        model_frame(3, 4, 5);
        checks++;
        if (cnt_seen[0] !== exp_cnt_seq[0]) begin
            errors++;
            $display("FAIL wd_recover_count: got %0d expected %0d", cnt_seen[0], exp_cnt_seq[0]);
        end
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL wd_recover_idle: got state %0d expected 0", state);
        end
    endtask

    task automatic test_race();
        clear_traces();
        continuous = 1'b0;
        // every done lands on the final watchdog count of its phase
        run_frame(TMO, TMO, TMO, 1'b1, 1'b0, 1'b0);
        model_frame(TMO, TMO, TMO);
        checks++;
        if (tr_state.size() != exp_state.size()) begin
            errors++;
            $display("FAIL race_len: got %0d expected %0d", tr_state.size(), exp_state.size());
        end else begin
            for (int i = 0; i < exp_state.size(); i++) begin
                checks++;
                if (tr_state[i] !== exp_state[i] || tr_outs[i] !== exp_outs(exp_state[i])) begin
                    errors++;
                    $display("FAIL race_trace[%0d]: state=%0d outs=%b expected state=%0d outs=%b",
                             i, tr_state[i], tr_outs[i], exp_state[i], exp_outs(exp_state[i]));
                end
            end
        end
        checks++;
        if (cnt_seen[0] !== exp_cnt_seq[0]) begin
            errors++;
            $display("FAIL race_count: got %0d expected %0d", cnt_seen[0], exp_cnt_seq[0]);
        end
    endtask

    task automatic test_stray();
        int d[6];
        clear_traces();
        continuous = 1'b0;
        gs_done = 1'b1; rd_done = 1'b1; cam_done = 1'b1; stop = 1'b1;
        tick();
        gs_done = 1'b0; rd_done = 1'b0; cam_done = 1'b0; stop = 1'b0;
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL stray_idle: got state %0d expected 0", state);
        end
        // the stop seen in IDLE must not halt a continuous run
        continuous = 1'b1;
        for (int i = 0; i < 6; i++) d[i] = $urandom_range(1, 14);
        run_frame(d[0], d[1], d[2], 1'b1, 1'b0, 1'b1);
        run_frame(d[3], d[4], d[5], 1'b0, 1'b1, 1'b1);
        model_frame(d[0], d[1], d[2]);
        model_frame(d[3], d[4], d[5]);
        continuous = 1'b0;
        checks++;
        if (tr_state.size() != exp_state.size()) begin
            errors++;
            $display("FAIL stray_len: got %0d expected %0d", tr_state.size(), exp_state.size());
        end else begin
            for (int i = 0; i < exp_state.size(); i++) begin
                checks++;
                if (tr_state[i] !== exp_state[i] || tr_outs[i] !== exp_outs(exp_state[i])) begin
                    errors++;
                    $display("FAIL stray_trace[%0d]: state=%0d outs=%b expected state=%0d outs=%b",
                             i, tr_state[i], tr_outs[i], exp_state[i], exp_outs(exp_state[i]));
                end
            end
        end
        for (int f = 0; f < 2; f++) begin
            checks++;
            if (cnt_seen[f] !== exp_cnt_seq[f]) begin
                errors++;
                $display("FAIL stray_count[%0d]: got %0d expected %0d", f, cnt_seen[f], exp_cnt_seq[f]);
            end
        end
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL stray_end: got state %0d expected 0", state);
        end
    endtask

    task automatic test_wrap_reset();
        int wrap_seq[5];
        wrap_seq[0] = 1; wrap_seq[1] = 2; wrap_seq[2] = 3; wrap_seq[3] = 0; wrap_seq[4] = 1;
        clear_traces();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        tick();
        continuous = 1'b1;
        for (int f = 0; f < 5; f++) begin
            int d1, d2, d3;
            d1 = $urandom_range(1, 6);
            d2 = $urandom_range(1, 6);
            d3 = $urandom_range(1, 6);
            run_frame(d1, d2, d3, (f == 0), 1'b0, 1'b0);
            model_frame(d1, d2, d3);
        end
        for (int f = 0; f < 5; f++) begin
            checks++;
            if (cnt_seen[f] !== wrap_seq[f] || cnt_seen[f] !== exp_cnt_seq[f]) begin
                errors++;
                $display("FAIL wrap_count[%0d]: got %0d expected %0d", f, cnt_seen[f], wrap_seq[f]);
            end
        end
        // sixth frame: into GRAY, then asynchronous reset between edges
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL wrap_next_capture: got state %0d expected 1", state);
        end
        cam_done = 1'b1;
        tick();
        cam_done = 1'b0;
        tick();
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL wrap_gray: got state %0d expected 2", state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || outs !== 10'd0 || frame_count !== '0) begin
            errors++;
            $display("FAIL async_reset: state=%0d outs=%b count=%0d expected all 0", state, outs, frame_count);
        end
        continuous = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        tick();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got state %0d expected 0", state);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_continuous_stop();
        test_watchdog();
        test_race();
        test_stray();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
